// File: rtl/stopwatch_bcd_counter.sv
// Four-digit (parameterizable) BCD run/pause counter advanced by rising edges
// of an asynchronous divided-clock tick, with IDLE/RUN/PAUSE control.

module stopwatch_bcd_digit (
    input  logic       i_cin,
    input  logic [3:0] i_d,
    output logic [3:0] o_d,
    output logic       o_cout
);
    // Illegal codes 10-15 behave like 9 so a corrupted digit self-heals.
    logic w_top;
    assign w_top  = (i_d >= 4'd9);
    assign o_cout = i_cin & w_top;
    assign o_d    = !i_cin ? i_d : (w_top ? 4'd0 : i_d + 4'd1);
endmodule

module stopwatch_bcd_counter #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  I_CLK,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  wrap
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_hist;
    logic                    w_tick_edge, w_count;
    logic [4*DIGITS-1:0]     r_bcd, w_bcd_inc;
    logic [DIGITS:0]         w_carry;
    logic                    r_running, r_wrap;

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // stop outranks start, so a stop in the same cycle also blocks a start.
    always_comb begin
        w_state_nxt = r_state;
        if (clr)
            w_state_nxt = IDLE;
        else if (stop) begin
            if (r_state == RUN) w_state_nxt = PAUSE;
        end else if (start) begin
            if (r_state != RUN) w_state_nxt = RUN;
        end
    end

    assign w_count    = (r_state == RUN) & w_tick_edge & ~clr & ~stop;
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        stopwatch_bcd_digit u_dig (
            .i_cin  (w_carry[g]),
            .i_d    (r_bcd[4*g +: 4]),
            .o_d    (w_bcd_inc[4*g +: 4]),
            .o_cout (w_carry[g+1])
        );
    end

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd     <= '0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_running <= (w_state_nxt == RUN);
            if (clr) begin
                r_bcd  <= '0;
                r_wrap <= 1'b0;
            end else if (w_count) begin
                r_bcd  <= w_bcd_inc;
                r_wrap <= w_carry[DIGITS];
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign bcd     = r_bcd;
    assign running = r_running;
    assign wrap    = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench: a decimal-integer reference model predicts every cycle's
// outputs; a forked monitor pops and compares them on the falling edge.

module tb_stopwatch_bcd_counter;
    localparam int D = 4;
    localparam int S = 2;

    logic I_CLK = 1'b0, rst_n = 1'b0, tick_in = 1'b0;
    logic start = 1'b0, stop = 1'b0, clr = 1'b0;
    logic [4*D-1:0] bcd;
    logic running, wrap;

    stopwatch_bcd_counter #(.DIGITS(D), .SYNC_STAGES(S)) dut (
        .I_CLK(I_CLK), .rst_n(rst_n), .tick_in(tick_in), .start(start),
        .stop(stop), .clr(clr), .bcd(bcd), .running(running), .wrap(wrap)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [4*D-1:0] bcd;
        logic           run;
        logic           wrp;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0, errors = 0;

    // Model: count as a plain integer, state 0=idle 1=run 2=pause,
    // tick history as raw per-edge samples of tick_in.
    int   m_cnt, m_st;
    bit   m_wrap;
    bit   m_smp[S+2];

    function automatic logic [4*D-1:0] to_bcd(int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_st   = 0;
        m_wrap = 0;
        for (int i = 0; i < S + 2; i++) m_smp[i] = 0;
    endtask

    task automatic step();
        bit e;
        @(posedge I_CLK);
        if (!rst_n) model_reset();
        else begin
            for (int j = S + 1; j > 0; j--) m_smp[j] = m_smp[j-1];
            m_smp[0] = tick_in;
            e = m_smp[S] && !m_smp[S+1];
            m_wrap = 0;
            if (clr) begin
                m_st  = 0;
                m_cnt = 0;
            end else if (stop) begin
                if (m_st == 1) m_st = 2;
            end else if (start && m_st != 1) begin
                m_st = 1;
            end else if (m_st == 1 && e) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 10**D) begin
                    m_cnt  = 0;
                    m_wrap = 1;
                end
            end
        end
        sb.push_back('{to_bcd(m_cnt), m_st == 1, m_wrap});
        #2;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(int n, int hi, int lo);
        repeat (n) begin
            tick_in = 1'b1;
            repeat (hi) step();
            tick_in = 1'b0;
            repeat (lo) step();
        end
    endtask

    task automatic set_ctl(int c);
        start = (c == 1);
        stop  = (c == 2);
        clr   = (c == 3);
    endtask

    task automatic ctl(int c);
        set_ctl(c);
        step();
        set_ctl(0);
    endtask

    // Control pulse lands on the same edge as the detected tick edge.
    task automatic tick_with(int c);
        tick_in = 1'b1;
        repeat (S) step();
        ctl(c);
        step();
        tick_in = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        fork
            forever begin
                @(negedge I_CLK);
                if (sb.size() > 0) begin
                    me = sb.pop_front();
                    checks++;
                    if (bcd !== me.bcd || running !== me.run || wrap !== me.wrp) begin
                        errors++;
                        $display("FAIL cycle t=%0t: got bcd=%h run=%b wrap=%b expected bcd=%h run=%b wrap=%b",
                                 $time, bcd, running, wrap, me.bcd, me.run, me.wrp);
                    end
                end
            end
        join_none

        model_reset();
        tick(5, 2, 2);
        rst_n = 1'b1;
        tick(3, 2, 2);
        chk("idle_bcd", 32'(bcd), 32'h0);
        chk("idle_run", 32'(running), 32'h0);

        ctl(1);
        tick(12, 10, 10);
        chk("count12", 32'(bcd), 32'h0012);

        ctl(2);
        chk("pause_run", 32'(running), 32'h0);
        tick(4, 10, 10);
        chk("pause_hold", 32'(bcd), 32'h0012);
        ctl(1);
        tick(3, 10, 10);
        chk("resume", 32'(bcd), 32'h0015);

        tick(9998 - 15, 2, 2);
        chk("pre_9998", 32'(bcd), 32'h9998);
        tick(1, 2, 2);
        chk("at_9999", 32'(bcd), 32'h9999);
        tick_in = 1'b1;
        repeat (S + 1) step();
        chk("wrap_bcd", 32'(bcd), 32'h0);
        chk("wrap_pulse", 32'(wrap), 32'h1);
        step();
        chk("wrap_drop", 32'(wrap), 32'h0);
        tick_in = 1'b0;
        repeat (2) step();
        tick(1, 2, 2);
        chk("after_wrap", 32'(bcd), 32'h0001);

        tick(39, 2, 2);
        chk("at_0040", 32'(bcd), 32'h0040);
        tick_with(2);
        chk("stop_tick_bcd", 32'(bcd), 32'h0040);
        chk("stop_tick_run", 32'(running), 32'h0);
        ctl(1);
        tick_with(3);
        chk("clr_tick_bcd", 32'(bcd), 32'h0);
        chk("clr_tick_run", 32'(running), 32'h0);
        tick_with(1);
        chk("start_tick_bcd", 32'(bcd), 32'h0);
        chk("start_tick_run", 32'(running), 32'h1);
        tick(1, 2, 2);
        chk("start_then_tick", 32'(bcd), 32'h0001);

        tick(306, 2, 2);
        chk("at_0307", 32'(bcd), 32'h0307);
        @(negedge I_CLK);
        #1 rst_n = 1'b0;
        #1;
        chk("async_bcd", 32'(bcd), 32'h0);
        chk("async_run", 32'(running), 32'h0);
        chk("async_wrap", 32'(wrap), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        tick(3, 2, 2);
        chk("post_rst_bcd", 32'(bcd), 32'h0);
        chk("post_rst_run", 32'(running), 32'h0);

        repeat (300) begin
            tick_in = ~tick_in;
            repeat ($urandom_range(2, 6)) begin
                int c;
                c = int'($urandom_range(0, 29));
                set_ctl(c <= 2 ? 1 : (c == 3 ? 2 : (c == 4 ? 3 : 0)));
                step();
            end
            set_ctl(0);
        end

        tick_in = 1'b0;
        repeat (3) step();
        @(negedge I_CLK);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Four-digit BCD run/pause counter clocked by the system clock. It consumes the divided slow clock from the clock divider as a tick input. Each rising edge of that tick advances the count while the block is running. It sits directly downstream of the divider and feeds the board's display/scan logic with a packed BCD value, a run status and a wrap pulse.

## Interface
- `DIGITS`, default 4: number of BCD digits. `bcd` width is 4*DIGITS.
- `SYNC_STAGES`, default 2: synchronizer depth on `tick_in`. Legal values are 2 or more.

- `I_CLK`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `tick_in`  in  1  divided clock from the divider; treated as asynchronous, level signal
- `start`  in  1  one-cycle pulse (level tolerated); IDLE/PAUSE -> RUN
- `stop`  in  1  one-cycle pulse; RUN -> PAUSE
- `clr`  in  1  one-cycle pulse; zero the count, go to IDLE
- `bcd`  out  4*DIGITS  packed count; digit 0 (units) in bits [3:0]
- `running`  out  1  high while in RUN
- `wrap`  out  1  one-cycle pulse when the count rolls from all-9s to all-0s

## Operation
- Synchronizer: `tick_in` passes through SYNC_STAGES flops, then one history flop.
  - `tick_edge` = last sync stage & ~history. It is one `I_CLK` cycle wide per tick rising edge.
  - Falling edges are ignored.
- State machine (registered), states IDLE, RUN, PAUSE. Priority per cycle: `clr` > `stop` > `start`.
  - `clr` from any state -> IDLE; `bcd` is cleared to 0 on the same edge.
  - IDLE: `start` -> RUN.
  - RUN: `stop` -> PAUSE.
  - PAUSE: `start` -> RUN. The count is held.
  - `stop` in IDLE/PAUSE and `start` in RUN are ignored.
- Counting happens on an edge only when all three hold: current state is RUN, `tick_edge`=1, and neither `clr` nor `stop` is asserted in that cycle.
- Increment is BCD ripple.
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Digit values 10–15 never occur. If one is forced, it is treated as 9 (rolls to 0 with carry).
- Wrap: all digits 9 plus a count -> all digits 0, with `wrap`=1 for exactly that one cycle. The count continues in RUN.
- `running` = (state == RUN), registered.
- Reset values:
  - state IDLE
  - `bcd`=0
  - `running`=0
  - `wrap`=0
  - all synchronizer and history flops 0
- Reset mid-count: asynchronous return to these values. No tick is counted on the first edge after `rst_n` deasserts unless the full synchronizer path sees a new 0->1.
- `tick_in` high at reset release creates an edge after SYNC_STAGES cycles. It is harmless because the state is IDLE.

## Timing
- Tick latency: `tick_in` first sampled high at edge k (low at k-1) with SYNC_STAGES=2.
  - `tick_edge` is high during cycle k+1..k+2.
  - `bcd` updates at edge k+2.
  - In general, `bcd` updates at edge k+SYNC_STAGES.
- `tick_in` high or low pulses shorter than one `I_CLK` period may be missed. The divider guarantees at least 2 periods per level.
- Control latency:
  - `start`/`stop`/`clr` sampled at edge n take effect at edge n.
  - `running` changes at edge n.
  - `bcd` clears at edge n for `clr`.
- Simultaneous events:
  - `start` with `tick_edge` in IDLE/PAUSE: no count; RUN from n.
  - `stop` with `tick_edge` in RUN: no count.
  - `clr` with anything: `bcd`=0, no `wrap`.
- `wrap` is asserted on the same edge the count becomes 0, and deasserted the next edge.
- Tick rate: at most one count per two `I_CLK` cycles, because the edge detector needs a low level in between.

## Test plan
- Reset and idle:
  - Hold `rst_n`=0, toggle `tick_in` 5 times -> `bcd`=0x0000, `running`=0, `wrap`=0 throughout.
  - Release reset, toggle 3 more times with no `start` -> still 0x0000.
- Basic count and latency:
  - `start`, then 12 `tick_in` rising edges (period 20 `I_CLK`) -> `bcd`=0x0012.
  - Each update lands exactly 2 `I_CLK` edges after `tick_in` is first sampled high.
- Pause and resume:
  - In RUN at 0x0012, `stop` -> `running`=0. Give 4 ticks -> `bcd` stays 0x0012.
  - `start`, then 3 ticks -> 0x0015.
- Carry and wrap:
  - Preload by counting to 0x9998, then 2 ticks -> 0x9999, then 0x0000 with a 1-cycle `wrap`=1.
  - Next tick -> 0x0001 with `wrap`=0.
- Simultaneous events:
  - `stop` coincident with `tick_edge` at 0x0040 -> `bcd` stays 0x0040.
  - `clr` coincident with `tick_edge` -> 0x0000, state IDLE.
  - `start` coincident with `tick_edge` in IDLE -> 0x0000, then counts from the next tick.
- Asynchronous reset mid-run: at 0x0307 in RUN, pulse `rst_n` low between clock edges -> outputs are 0 immediately. After release, no count until `start`.
